// File: rtl/arm_mc_ctrl_if.sv
// Control/handshake bus between the multicycle ARM controller (master)
// and its datapath plus memory port (slave).
interface arm_mc_ctrl_if #(
   parameter int ALUC_W = 2
);
   logic [31:0]       Instr;
   logic [3:0]        ALUFlags;
   logic              mem_ready;
   logic              mem_req;
   logic              PCWrite;
   logic              IRWrite;
   logic              RegWrite;
   logic              MemWrite;
   logic              AdrSrc;
   logic              ALUSrcA;
   logic [1:0]        ALUSrcB;
   logic [1:0]        ResultSrc;
   logic [1:0]        ImmSrc;
   logic [1:0]        RegSrc;
   logic [ALUC_W-1:0] ALUControl;
   logic              fault;

   modport master (
      input  Instr, ALUFlags, mem_ready,
      output mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
             ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, fault
   );

   modport slave (
      output Instr, ALUFlags, mem_ready,
      input  mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
             ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, fault
   );
endinterface

// File: rtl/arm_mc_ctrl.sv
// Multicycle ARM controller FSM with memory handshake and condition flags.
// Define MC_TIMEOUT_EN to add the memory-wait timeout that latches FAULT.
module arm_mc_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ALUC_W         = 2
) (
   input  logic          clk,
   input  logic          reset,
   arm_mc_ctrl_if.master mc_io
);
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_FAULT
   } state_t;

   typedef struct packed {
      logic              mem_req;
      logic              pc_write;
      logic              ir_write;
      logic              reg_write;
      logic              mem_write;
      logic              adr_src;
      logic              alu_src_a;
      logic [1:0]        alu_src_b;
      logic [1:0]        result_src;
      logic [1:0]        imm_src;
      logic [1:0]        reg_src;
      logic [ALUC_W-1:0] alu_ctl;
   } ctl_t;

   localparam logic [3:0] CMD_CMP = 4'b1010;

   state_t            state_q, state_d, state_nx;
   logic [3:0]        flags_q, flags_d;
   ctl_t              ctl, ctl_o;
   logic              timeout;
   logic              cond_ok, alu_ok;
   logic [ALUC_W-1:0] alu_dec;

   logic [3:0] cond, cmd, rd;
   logic [1:0] op;
   logic       i_bit, s_bit;
   logic       n_f, z_f, c_f, v_f;
   logic       unused_instr;

   assign cond  = mc_io.Instr[31:28];
   assign op    = mc_io.Instr[27:26];
   assign i_bit = mc_io.Instr[25];
   assign cmd   = mc_io.Instr[24:21];
   assign s_bit = mc_io.Instr[20];
   assign rd    = mc_io.Instr[15:12];
   assign unused_instr = ^{mc_io.Instr[19:16], mc_io.Instr[11:0]};

   assign {n_f, z_f, c_f, v_f} = flags_q;

   always_comb begin
      case (cond)
         4'h0:    cond_ok = z_f;
         4'h1:    cond_ok = !z_f;
         4'h2:    cond_ok = c_f;
         4'h3:    cond_ok = !c_f;
         4'h4:    cond_ok = n_f;
         4'h5:    cond_ok = !n_f;
         4'h6:    cond_ok = v_f;
         4'h7:    cond_ok = !v_f;
         4'h8:    cond_ok = c_f && !z_f;
         4'h9:    cond_ok = !c_f || z_f;
         4'hA:    cond_ok = (n_f == v_f);
         4'hB:    cond_ok = (n_f != v_f);
         4'hC:    cond_ok = !z_f && (n_f == v_f);
         4'hD:    cond_ok = z_f || (n_f != v_f);
         4'hE:    cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   // EOR only exists when ALUControl is wide enough to encode it
   always_comb begin
      alu_ok  = 1'b1;
      alu_dec = '0;
      case (cmd)
         4'b0100:          alu_dec = ALUC_W'(0);
         4'b0010, CMD_CMP: alu_dec = ALUC_W'(1);
         4'b0000:          alu_dec = ALUC_W'(2);
         4'b1100:          alu_dec = ALUC_W'(3);
         4'b0001: begin
            if (ALUC_W >= 3) alu_dec = ALUC_W'(4);
            else             alu_ok  = 1'b0;
         end
         default:          alu_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_FETCH;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
      end
   end

   always_comb begin
      state_nx = state_q;
      flags_d  = flags_q;
      ctl      = '0;
      if (state_q != S_FAULT) begin
         ctl.imm_src = op;
         ctl.reg_src = {(op == 2'b01) && !s_bit, op == 2'b10};
      end
      case (state_q)
         S_FETCH: begin
            ctl.mem_req    = 1'b1;
            ctl.alu_src_a  = 1'b1;
            ctl.alu_src_b  = 2'b10;
            ctl.result_src = 2'b10;
            ctl.ir_write   = mc_io.mem_ready;
            ctl.pc_write   = mc_io.mem_ready;
            if (mc_io.mem_ready) state_nx = S_DECODE;
         end
         S_DECODE: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = 2'b10;
            if (!cond_ok)           state_nx = S_FETCH;
            else if (op == 2'b01)   state_nx = S_MEMADR;
            else if (op == 2'b10)   state_nx = S_BRANCH;
            else if (op == 2'b00)   state_nx = i_bit ? S_EXECI : S_EXECR;
            else                    state_nx = S_FETCH;
         end
         S_MEMADR: begin
            ctl.alu_src_b = 2'b01;
            state_nx      = s_bit ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            ctl.mem_req = 1'b1;
            ctl.adr_src = 1'b1;
            if (mc_io.mem_ready) state_nx = S_MEMWB;
         end
         S_MEMWR: begin
            ctl.mem_req   = 1'b1;
            ctl.mem_write = 1'b1;
            ctl.adr_src   = 1'b1;
            if (mc_io.mem_ready) state_nx = S_FETCH;
         end
         S_MEMWB: begin
            ctl.result_src = 2'b01;
            ctl.reg_write  = 1'b1;
            ctl.pc_write   = (rd == 4'hF);
            state_nx       = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            ctl.alu_src_b = (state_q == S_EXECI) ? 2'b01 : 2'b00;
            ctl.alu_ctl   = alu_dec;
            if (s_bit || cmd == CMD_CMP) flags_d = mc_io.ALUFlags;
            state_nx = (alu_ok && cmd != CMD_CMP) ? S_ALUWB : S_FETCH;
         end
         S_ALUWB: begin
            ctl.reg_write = 1'b1;
            ctl.pc_write  = (rd == 4'hF);
            state_nx      = S_FETCH;
         end
         S_BRANCH: begin
            ctl.alu_src_b  = 2'b01;
            ctl.result_src = 2'b10;
            ctl.pc_write   = 1'b1;
            state_nx       = S_FETCH;
         end
         S_FAULT: state_nx = S_FAULT;
         default: state_nx = S_FETCH;
      endcase
   end

   assign state_d = timeout ? S_FAULT : state_nx;

`ifdef MC_TIMEOUT_EN
   // Wait count runs only while a requesting state sees no mem_ready
   logic [7:0] wait_q, wait_d;
   logic       mem_wait;

   assign mem_wait = (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR)
                     && !mc_io.mem_ready;

   always_comb begin
      wait_d  = '0;
      timeout = 1'b0;
      if (mem_wait) begin
         wait_d  = wait_q + 8'd1;
         timeout = (wait_d == 8'(TIMEOUT_CYCLES));
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)                 wait_q <= '0;
      else if (state_d != state_q) wait_q <= '0;
      else                        wait_q <= wait_d;
   end

   assign mc_io.fault = reset && (state_q == S_FAULT);
`else
   assign timeout     = 1'b0;
   assign mc_io.fault = 1'b0;
`endif

   assign ctl_o = reset ? ctl : '0;

   assign mc_io.mem_req    = ctl_o.mem_req;
   assign mc_io.PCWrite    = ctl_o.pc_write;
   assign mc_io.IRWrite    = ctl_o.ir_write;
   assign mc_io.RegWrite   = ctl_o.reg_write;
   assign mc_io.MemWrite   = ctl_o.mem_write;
   assign mc_io.AdrSrc     = ctl_o.adr_src;
   assign mc_io.ALUSrcA    = ctl_o.alu_src_a;
   assign mc_io.ALUSrcB    = ctl_o.alu_src_b;
   assign mc_io.ResultSrc  = ctl_o.result_src;
   assign mc_io.ImmSrc     = ctl_o.imm_src;
   assign mc_io.RegSrc     = ctl_o.reg_src;
   assign mc_io.ALUControl = ctl_o.alu_ctl;
endmodule
